// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and opcode field layout used by fetch and controller.
package cpu_pkg;

    localparam int unsigned OP_WIDTH  = 5;
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned CNT_WIDTH = 32;

    localparam logic [OP_WIDTH-1:0]  OP_HALT = 5'b11111;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [OP_WIDTH-1:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, PC-relative branch, or region-relative jump.
module pc_next_logic #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_instr,
    input  logic             i_pcsrc,
    input  logic             i_jump,
    output logic [WIDTH-1:0] o_pc_plus4,
    output logic [WIDTH-1:0] o_next_pc
);

    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_br_target;
    logic [WIDTH-1:0] w_jmp_target;

    assign o_pc_plus4   = i_pc + WIDTH'(4);
    assign w_imm_ext    = {{(WIDTH-16){i_instr[15]}}, i_instr[15:0]};
    assign w_br_target  = o_pc_plus4 + (w_imm_ext << 2);
    // Jump keeps the top region bits of pc+4 and replaces the rest with the word index.
    assign w_jmp_target = {o_pc_plus4[WIDTH-1:29], i_instr[26:0], 2'b00};

    always_comb begin
        o_next_pc = o_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jmp_target;
        end else if (i_pcsrc) begin
            o_next_pc = w_br_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, req/ack handshake to imem, held instruction, sticky HALT.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [WIDTH-1:0]    imem_addr,
    input  logic                imem_ack,
    input  logic [WIDTH-1:0]    imem_rdata,
    output logic                instr_valid,
    output logic [WIDTH-1:0]    instr,
    output logic [OP_WIDTH-1:0] op,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus4,
    input  logic                ex_ready,
    input  logic                pcsrc,
    input  logic                jump,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_instr;
    logic               r_imem_req;
    logic               r_instr_valid;
    logic               r_halted;
    logic               w_req_nxt;
    logic               w_valid_nxt;
    logic               w_halted_nxt;
    logic               w_accept;
    logic               w_retire;
    logic [OP_WIDTH-1:0] w_op;
    logic [WIDTH-1:0]   w_pc_plus4;
    logic [WIDTH-1:0]   w_next_pc;

    assign w_op     = r_instr[OP_MSB:OP_LSB];
    assign w_accept = (r_state == S_REQ) && imem_ack;
    assign w_retire = (r_state == S_HOLD) && ex_ready;

    pc_next_logic #(
        .WIDTH (WIDTH)
    ) u_pc_next_logic (
        .i_pc       (r_pc),
        .i_instr    (r_instr),
        .i_pcsrc    (pcsrc),
        .i_jump     (jump),
        .o_pc_plus4 (w_pc_plus4),
        .o_next_pc  (w_next_pc)
    );

    // State register; status outputs are registered from the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_imem_req    <= w_req_nxt;
            r_instr_valid <= w_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (ex_ready) begin
                    w_state_nxt = is_halt(w_op) ? S_HALT : S_REQ;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_halted_nxt = 1'b0;
        case (w_state_nxt)
            S_REQ:   w_req_nxt    = 1'b1;
            S_HOLD:  w_valid_nxt  = 1'b1;
            S_HALT:  w_halted_nxt = 1'b1;
            default: ;
        endcase
    end

    // PC only advances on a non-HALT retire so a halted core keeps pointing at the HALT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            if (w_accept) begin
                r_instr <= imem_rdata;
            end
            if (w_retire && !is_halt(w_op)) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign op          = w_op;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign halted      = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_fetch_count;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 w_stall;

    assign w_stall = ((r_state == S_REQ) && !imem_ack) || ((r_state == S_HOLD) && !ex_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_retire && (r_fetch_count != CNT_MAX)) begin
                r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
            end
            if (w_stall && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_WIDTH'(1);
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against an address-sequence reference model.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               imem_req;
    logic [WIDTH-1:0]   imem_addr;
    logic               imem_ack;
    logic [WIDTH-1:0]   imem_rdata;
    logic               instr_valid;
    logic [WIDTH-1:0]   instr;
    logic [OP_WIDTH-1:0] op;
    logic [WIDTH-1:0]   pc;
    logic [WIDTH-1:0]   pc_plus4;
    logic               ex_ready;
    logic               pcsrc;
    logic               jump;
    logic               halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        fetch_count;
    logic [31:0]        stall_count;
`endif

    fetch_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ex_ready    (ex_ready),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] m_pc;
    int          m_fetches;
    int          m_stalls;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule expressed with plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input bit jmp, input bit br);
        logic [31:0]        p4;
        logic signed [15:0] imm;
        p4  = cur + 32'd4;
        imm = word[15:0];
        if (jmp) return (p4 & 32'hE000_0000) | ((word & 32'h07FF_FFFF) << 2);
        if (br)  return p4 + 32'(int'(imm) * 4);
        return p4;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == 5'h1F) w[31] = 1'b0;
        return w;
    endfunction

    // One full fetch: wait states, ack, optional stalls with noise on ignored inputs, retire.
    task automatic fetch_one(input int waits, input int stalls, input bit jmp, input bit br,
                             input logic [31:0] word);
        int lat;
        lat = 0;
        while (imem_req !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("req_latency", 32'(lat), 32'd0);
        check("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            step();
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, m_pc);
            check("valid_low_wait", 32'(instr_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr", instr, word);
        check("op", 32'(op), 32'(word[31:27]));
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("req_low_hold", 32'(imem_req), 32'd0);
        for (int i = 0; i < stalls; i++) begin
            jump       = 1'($urandom);
            pcsrc      = 1'($urandom);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            check("stall_instr", instr, word);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        ex_ready = 1'b1;
        jump     = jmp;
        pcsrc    = br;
        step();
        ex_ready = 1'b0;
        jump     = 1'b0;
        pcsrc    = 1'b0;
        m_fetches++;
        m_stalls += waits + stalls;
        if (word[31:27] != 5'h1F) m_pc = model_next(m_pc, word, jmp, br);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset_n    = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ex_ready   = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        #2 reset_n = 1'b0;
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        reset_n = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        step();
        m_pc      = 32'h0;
        m_fetches = 0;
        m_stalls  = 0;

        // Zero-wait back-to-back stream: two cycles per instruction.
        c0 = cyc;
        for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b0, 1'b0, rand_word());
        check("throughput_cycles", 32'(cyc - c0), 32'd8);

        // Backward branch from 0x10 by imm -2 words.
        fetch_one(1, 1, 1'b0, 1'b1, {5'h01, 11'h0, 16'hFFFE});
        check("branch_back", imem_addr, 32'h0000_000C);
        // Jump beats branch.
        fetch_one(0, 0, 1'b1, 1'b1, {5'h02, 27'h40});
        check("jump_to_100", imem_addr, 32'h0000_0100);
        fetch_one(0, 0, 1'b1, 1'b1, {5'h02, 27'h40});
        check("jump_wins", imem_addr, 32'h0000_0100);
        // Branch below zero to the top word, then sequential wrap to zero.
        fetch_one(2, 0, 1'b0, 1'b1, {5'h03, 11'h0, 16'hFFBE});
        check("top_word", imem_addr, 32'hFFFF_FFFC);
        fetch_one(0, 0, 1'b0, 1'b0, rand_word());
        check("wrap_zero", imem_addr, 32'h0);
        // Three wait states.
        fetch_one(3, 0, 1'b0, 1'b0, rand_word());

        for (int i = 0; i < 150; i++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), rand_word());
        end
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count_run", fetch_count, 32'(m_fetches));
        check("stall_count_run", stall_count, 32'(m_stalls));
`endif

        // Reset during a wait state; stale acks in reset and IDLE must be dropped.
        check("pre_rst_req", 32'(imem_req), 32'd1);
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        reset_n = 1'b1;
        step();
        imem_ack = 1'b0;
        check("idle_ack_ignored", instr, 32'h0);
        check("refetch_valid", 32'(instr_valid), 32'd0);
        check("refetch_req", 32'(imem_req), 32'd1);
        m_pc      = 32'h0;
        m_fetches = 0;
        m_stalls  = 0;
        for (int i = 0; i < 3; i++) fetch_one(1, 1, 1'b0, 1'b0, rand_word());
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count3", fetch_count, 32'd3);
        check("stall_count6", stall_count, 32'd6);
`endif

        // HALT retire is sticky until reset.
        fetch_one(1, 2, 1'b0, 1'b0, {5'h1F, 27'h123});
        check("halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1'($urandom);
            ex_ready = 1'($urandom);
            step();
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_sticky", 32'(halted), 32'd1);
        end
        imem_ack = 1'b0;
        ex_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count_halt", fetch_count, 32'd4);
`endif
        reset_n = 1'b0;
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("post_halt_req", 32'(imem_req), 32'd1);
        check("post_halt_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
